ndn_content_responder: RTL

Upstream producer model for the NDN router's outgoing face. It accepts an interest forwarded by the router and answers it from a small internal content store. The interest arrives as `ready_for_data` plus the longest-matching prefix and its length. A hit returns a Data packet on the router's data-in face (`data_in_prefix`, `data_in_len`, `data_ready`, `in_data`), byte-serial. The block serves as the far end of the router's upstream link in system benches and in FPGA loopback builds.

---
 rtl/ndn_content_responder.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/ndn_content_responder.sv
// Purpose : upstream producer model; answers a forwarded interest from a small
//           content store with a byte-serial Data packet, or a NACK on a miss.
// Latency : first payload byte (or nack) appears on the outputs after the
//           second edge following interest acceptance.
// Backpressure: none; a burst always runs to completion. An interest held
//           high is served once, then the block waits for interest_valid=0.
//
// Ports:
//   clk, rst (synchronous, active-low)
//   interest_valid/_prefix/_len : interest from the router (ready_for_data,
//                                 longest matching prefix and its length)
//   store_we/_idx/_prefix/_len/_content/_content_len : content-store write port
//   data_in_prefix/_len, data_ready, in_data, data_last : Data packet out
//   nack : one-cycle miss pulse; busy : high whenever not IDLE
//
// Build option: define NDN_RESPONDER_NACK_EN to pulse nack on a store miss;
// when undefined, nack is tied low and a miss is silent.

module ndn_content_responder #(
  parameter int ENTRIES = 4,
  parameter int IDX_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               interest_valid,
  input  logic [63:0]        interest_prefix,
  input  logic [5:0]         interest_len,
  input  logic               store_we,
  input  logic [IDX_W-1:0]   store_idx,
  input  logic [63:0]        store_prefix,
  input  logic [5:0]         store_len,
  input  logic [63:0]        store_content,
  input  logic [3:0]         store_content_len,
  output logic [63:0]        data_in_prefix,
  output logic [5:0]         data_in_len,
  output logic               data_ready,
  output logic [7:0]         in_data,
  output logic               data_last,
  output logic               nack,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, LOOKUP, SEND, DRAIN} state_e;

  state_e state_q, state_d;

  // Content store
  logic [63:0] st_prefix_q  [ENTRIES];
  logic [5:0]  st_len_q     [ENTRIES];
  logic [63:0] st_content_q [ENTRIES];
  logic [3:0]  st_clen_q    [ENTRIES];

  // Latched interest
  logic [63:0] req_prefix_q, req_prefix_d;
  logic [5:0]  req_len_q, req_len_d;

  // Private copy of the hit entry so store writes cannot disturb a burst
  logic [63:0] snd_content_q, snd_content_d;
  logic [3:0]  snd_clen_q, snd_clen_d;
  logic [2:0]  cnt_q, cnt_d;

  // Registered outputs
  logic [63:0] prefix_q, prefix_d;
  logic [5:0]  plen_q, plen_d;
  logic        data_ready_q, data_ready_d;
  logic [7:0]  in_data_q, in_data_d;
  logic        data_last_q, data_last_d;
  logic        nack_q, nack_d;
  logic        busy_q, busy_d;

  logic [3:0] wr_clen_clamped;

  assign wr_clen_clamped = (store_content_len > 4'd8) ? 4'd8 : store_content_len;

  // Store write port: usable in any state, visible from the next edge on
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        st_prefix_q[i]  <= '0;
        st_len_q[i]     <= '0;
        st_content_q[i] <= '0;
        st_clen_q[i]    <= '0;
      end
    end else if (store_we) begin
      st_prefix_q[store_idx]  <= store_prefix;
      st_len_q[store_idx]     <= store_len;
      st_content_q[store_idx] <= store_content;
      st_clen_q[store_idx]    <= wr_clen_clamped;
    end
  end

  // Parallel match against the latched interest. Scanning from the top down
  // lets the lowest matching index overwrite any higher one.
  logic [63:0]      len_mask;
  logic             hit_any;
  logic [IDX_W-1:0] hit_idx;

  always_comb begin
    len_mask = ~({64{1'b1}} << req_len_q);
    hit_any  = 1'b0;
    hit_idx  = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if ((st_len_q[i] != 6'd0) && (st_clen_q[i] != 4'd0) &&
          (st_len_q[i] == req_len_q) &&
          (((st_prefix_q[i] ^ req_prefix_q) & len_mask) == 64'd0)) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    req_prefix_d  = req_prefix_q;
    req_len_d     = req_len_q;
    snd_content_d = snd_content_q;
    snd_clen_d    = snd_clen_q;
    cnt_d         = cnt_q;
    prefix_d      = prefix_q;
    plen_d        = plen_q;
    data_ready_d  = 1'b0;
    in_data_d     = 8'd0;
    data_last_d   = 1'b0;
    nack_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (interest_valid) begin
          req_prefix_d = interest_prefix;
          req_len_d    = interest_len;
          state_d      = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit_any) begin
          // Byte 0 is launched straight from the store; the rest come
          // from the private copy taken on the same edge.
          snd_content_d = st_content_q[hit_idx];
          snd_clen_d    = st_clen_q[hit_idx];
          prefix_d      = st_prefix_q[hit_idx];
          plen_d        = st_len_q[hit_idx];
          data_ready_d  = 1'b1;
          in_data_d     = st_content_q[hit_idx][7:0];
          data_last_d   = (st_clen_q[hit_idx] == 4'd1);
          cnt_d         = 3'd1;
          state_d       = SEND;
        end else begin
`ifdef NDN_RESPONDER_NACK_EN
          nack_d  = 1'b1;
`endif
          state_d = DRAIN;
        end
      end
      SEND: begin
        // data_last_q marks the byte currently on the outputs as final
        if (data_last_q) begin
          state_d = DRAIN;
        end else begin
          data_ready_d = 1'b1;
          in_data_d    = snd_content_q[{cnt_q, 3'b000} +: 8];
          data_last_d  = ({1'b0, cnt_q} == (snd_clen_q - 4'd1));
          cnt_d        = cnt_q + 3'd1;
        end
      end
      DRAIN: begin
        if (!interest_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      req_prefix_q  <= '0;
      req_len_q     <= '0;
      snd_content_q <= '0;
      snd_clen_q    <= '0;
      cnt_q         <= '0;
      prefix_q      <= '0;
      plen_q        <= '0;
      data_ready_q  <= 1'b0;
      in_data_q     <= '0;
      data_last_q   <= 1'b0;
      nack_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_prefix_q  <= req_prefix_d;
      req_len_q     <= req_len_d;
      snd_content_q <= snd_content_d;
      snd_clen_q    <= snd_clen_d;
      cnt_q         <= cnt_d;
      prefix_q      <= prefix_d;
      plen_q        <= plen_d;
      data_ready_q  <= data_ready_d;
      in_data_q     <= in_data_d;
      data_last_q   <= data_last_d;
      nack_q        <= nack_d;
      busy_q        <= busy_d;
    end
  end

  assign data_in_prefix = prefix_q;
  assign data_in_len    = plen_q;
  assign data_ready     = data_ready_q;
  assign in_data        = in_data_q;
  assign data_last      = data_last_q;
  assign nack           = nack_q;
  assign busy           = busy_q;

endmodule
